// File: rtl/wave_copy_sequencer.sv
// Sequences sample copies from main wave memory into per-consumer sample BRAMs,
// realigning read data against the fixed memory read latency.
module wave_copy_sequencer #(
    parameter int unsigned NUM_TARGETS     = 4,
    parameter int unsigned SAMPLE_WIDTH    = 16,
    parameter int unsigned WW_WIDTH        = 18,
    parameter int unsigned MMEM_ADDR_WIDTH = 18,
    parameter int unsigned READ_LATENCY    = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       req_valid_in,
    output logic                       req_ready_out,
    input  logic [MMEM_ADDR_WIDTH-1:0] req_base_in,
    input  logic [WW_WIDTH-1:0]        req_width_in,
    input  logic [NUM_TARGETS-1:0]     req_mask_in,
    input  logic                       abort_in,
    output logic [MMEM_ADDR_WIDTH-1:0] mem_addr_out,
    output logic                       mem_en_out,
    input  logic [SAMPLE_WIDTH-1:0]    mem_data_in,
    output logic [WW_WIDTH-1:0]        wr_addr_out,
    output logic [SAMPLE_WIDTH-1:0]    wr_data_out,
    output logic [NUM_TARGETS-1:0]     wr_en_out,
    output logic                       busy_out,
    output logic                       done_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;

    logic                       pend_valid;
    logic [MMEM_ADDR_WIDTH-1:0] pend_base;
    logic [WW_WIDTH-1:0]        pend_width;
    logic [NUM_TARGETS-1:0]     pend_mask;

    logic [WW_WIDTH-1:0]        act_width;
    logic [NUM_TARGETS-1:0]     act_mask;
    logic [WW_WIDTH-1:0]        rd_idx;

    // Stage 0 is loaded together with the read address, so the tail feeds the
    // registered write outputs exactly READ_LATENCY cycles after the read.
    logic [READ_LATENCY-1:0]    pipe_valid;
    logic [WW_WIDTH-1:0]        pipe_idx  [READ_LATENCY];
    logic [NUM_TARGETS-1:0]     pipe_mask [READ_LATENCY];

    logic accept_c;

    assign accept_c    = req_valid_in && req_ready_out;
    assign wr_data_out = mem_data_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= S_IDLE;
            pend_valid    <= 1'b0;
            pend_base     <= '0;
            pend_width    <= '0;
            pend_mask     <= '0;
            act_width     <= '0;
            act_mask      <= '0;
            rd_idx        <= '0;
            pipe_valid    <= '0;
            for (int unsigned k = 0; k < READ_LATENCY; k++) begin
                pipe_idx[k]  <= '0;
                pipe_mask[k] <= '0;
            end
            req_ready_out <= 1'b1;
            mem_en_out    <= 1'b0;
            mem_addr_out  <= '0;
            wr_en_out     <= '0;
            wr_addr_out   <= '0;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
        end else begin
            done_out <= 1'b0;

            for (int unsigned k = 1; k < READ_LATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                pipe_idx[k]   <= pipe_idx[k-1];
                pipe_mask[k]  <= pipe_mask[k-1];
            end
            pipe_valid[0] <= 1'b0;

            wr_en_out <= pipe_valid[READ_LATENCY-1] ? pipe_mask[READ_LATENCY-1] : '0;
            if (pipe_valid[READ_LATENCY-1]) begin
                wr_addr_out <= pipe_idx[READ_LATENCY-1];
            end

            if (accept_c) begin
                pend_valid    <= 1'b1;
                pend_base     <= req_base_in;
                pend_width    <= req_width_in;
                pend_mask     <= req_mask_in;
                req_ready_out <= 1'b0;
            end

            // Abort wins over everything except a request handshaking this cycle.
            if (abort_in) begin
                state      <= S_IDLE;
                mem_en_out <= 1'b0;
                busy_out   <= 1'b0;
                wr_en_out  <= '0;
                pipe_valid <= '0;
                if (!accept_c) begin
                    pend_valid    <= 1'b0;
                    req_ready_out <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (pend_valid) begin
                            pend_valid    <= 1'b0;
                            req_ready_out <= 1'b1;
                            act_width     <= pend_width;
                            act_mask      <= pend_mask;
                            busy_out      <= 1'b1;
                            if (pend_width == '0) begin
                                state    <= S_DONE;
                                done_out <= 1'b1;
                            end else begin
                                state         <= S_READ;
                                mem_en_out    <= 1'b1;
                                mem_addr_out  <= pend_base;
                                rd_idx        <= '0;
                                pipe_valid[0] <= 1'b1;
                                pipe_idx[0]   <= '0;
                                pipe_mask[0]  <= pend_mask;
                            end
                        end else begin
                            state    <= S_IDLE;
                            busy_out <= 1'b0;
                        end
                    end
                    S_READ: begin
                        if (rd_idx == act_width - WW_WIDTH'(1)) begin
                            state      <= S_DRAIN;
                            mem_en_out <= 1'b0;
                        end else begin
                            rd_idx        <= rd_idx + WW_WIDTH'(1);
                            mem_addr_out  <= mem_addr_out + MMEM_ADDR_WIDTH'(1);
                            mem_en_out    <= 1'b1;
                            pipe_valid[0] <= 1'b1;
                            pipe_idx[0]   <= rd_idx + WW_WIDTH'(1);
                            pipe_mask[0]  <= act_mask;
                        end
                    end
                    S_DRAIN: begin
                        if (pipe_valid == '0) begin
                            state    <= S_DONE;
                            done_out <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wave_copy_sequencer.sv
// Bench for wave_copy_sequencer: directed and random copy schedules compared
// cycle by cycle against a timeline computed from the copy timing rules.
module tb_wave_copy_sequencer;

    localparam int unsigned NT  = 4;
    localparam int unsigned SW  = 16;
    localparam int unsigned WW  = 18;
    localparam int unsigned AW  = 18;
    localparam int unsigned LAT = 2;
    localparam int H         = 192;
    localparam int MAXR      = 8;
    localparam int NO_ABORT  = 1000000;
    localparam int NPHASE    = 40;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          req_valid_in;
    logic          req_ready_out;
    logic [AW-1:0] req_base_in;
    logic [WW-1:0] req_width_in;
    logic [NT-1:0] req_mask_in;
    logic          abort_in;
    logic [AW-1:0] mem_addr_out;
    logic          mem_en_out;
    logic [SW-1:0] mem_data_in;
    logic [WW-1:0] wr_addr_out;
    logic [SW-1:0] wr_data_out;
    logic [NT-1:0] wr_en_out;
    logic          busy_out;
    logic          done_out;

    always #5 clk_in = ~clk_in;

    wave_copy_sequencer #(
        .NUM_TARGETS(NT), .SAMPLE_WIDTH(SW), .WW_WIDTH(WW),
        .MMEM_ADDR_WIDTH(AW), .READ_LATENCY(LAT)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_base_in(req_base_in), .req_width_in(req_width_in),
        .req_mask_in(req_mask_in), .abort_in(abort_in),
        .mem_addr_out(mem_addr_out), .mem_en_out(mem_en_out),
        .mem_data_in(mem_data_in), .wr_addr_out(wr_addr_out),
        .wr_data_out(wr_data_out), .wr_en_out(wr_en_out),
        .busy_out(busy_out), .done_out(done_out)
    );

    // Main memory: contents are a hash of the address, returned LAT cycles late.
    function automatic logic [SW-1:0] mem_val(input logic [AW-1:0] a);
        logic [AW-1:0] h;
        h = (a * AW'(7)) ^ (a >> 5) ^ AW'(18'h01234);
        return h[SW-1:0];
    endfunction

    logic [AW-1:0] addr_d [LAT];
    always @(posedge clk_in) begin
        addr_d[0] <= mem_addr_out;
        for (int k = 1; k < int'(LAT); k++) addr_d[k] <= addr_d[k-1];
    end
    always_comb mem_data_in = mem_val(addr_d[LAT-1]);

    int n_checks;
    int n_errors;
    int cyc;
    int phase;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s phase=%0d cycle=%0d got=%0h expected=%0h", tag, phase, cyc, got, exp);
        end
    endtask

    // Request schedule for one phase.
    int            req_a    [MAXR];
    logic [AW-1:0] req_base [MAXR];
    logic [WW-1:0] req_w    [MAXR];
    logic [NT-1:0] req_m    [MAXR];
    int            nreq;
    int            abort_x;
    int            end_e;
    int            last_d;

    bit            exp_en    [H];
    logic [AW-1:0] exp_addr  [H];
    logic [NT-1:0] exp_wen   [H];
    logic [WW-1:0] exp_widx  [H];
    logic [SW-1:0] exp_wdata [H];
    bit            exp_done  [H];
    bit            exp_busy  [H];
    bit            exp_rdy   [H];

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic set_req(input int k, input int a, input logic [AW-1:0] b,
                           input int w, input logic [NT-1:0] m);
        req_a[k] = a; req_base[k] = b; req_w[k] = WW'(w); req_m[k] = m;
    endtask

    // Timeline model: load when slot is full and engine free, reads start the
    // cycle after the load, writes trail reads by LAT, done after the last write.
    task automatic build_expect();
        int free, t, s, d, clip, w, c;
        for (int i = 0; i < H; i++) begin
            exp_en[i] = 0; exp_addr[i] = '0; exp_wen[i] = '0; exp_widx[i] = '0;
            exp_wdata[i] = '0; exp_done[i] = 0; exp_busy[i] = 0; exp_rdy[i] = 1;
        end
        free = 0;
        last_d = 0;
        for (int k = 0; k < nreq; k++) begin
            if (req_a[k] >= abort_x) begin
                clip = NO_ABORT;
                free = abort_x + 1;
            end else begin
                clip = abort_x;
            end
            t = imax(req_a[k] + 1, free);
            w = int'(req_w[k]);
            for (int i = req_a[k] + 1; i <= t; i++)
                if (i <= clip && i < H) exp_rdy[i] = 0;
            s = t + 1;
            d = (w == 0) ? t + 1 : s + w + int'(LAT);
            for (int i = 0; i < w; i++) begin
                c = s + i;
                if (c <= clip && c < H) begin
                    exp_en[c] = 1;
                    exp_addr[c] = req_base[k] + AW'(i);
                end
                c = s + i + int'(LAT);
                if (c <= clip && c < H) begin
                    exp_wen[c] = req_m[k];
                    exp_widx[c] = WW'(i);
                    exp_wdata[c] = mem_val(req_base[k] + AW'(i));
                end
            end
            if (d <= clip && d < H) exp_done[d] = 1;
            for (int i = t + 1; i <= d; i++)
                if (i <= clip && i < H) exp_busy[i] = 1;
            free = d;
            last_d = imax(last_d, (d < clip) ? d : clip);
        end
    endtask

    task automatic gen_random();
        int na, free, t, w, kept;
        int tk [MAXR];
        bit rdy_ok;
        nreq = $urandom_range(4, 1);
        na = 0;
        free = 0;
        t = 0;
        for (int k = 0; k < nreq; k++) begin
            req_a[k] = na + (($urandom_range(3, 0) == 0) ? $urandom_range(14, 0) : $urandom_range(2, 0));
            req_base[k] = ($urandom_range(3, 0) == 0) ? AW'(18'h3FFFF) - AW'($urandom_range(5, 0)) : AW'($urandom);
            w = ($urandom_range(4, 0) == 0) ? 0 : $urandom_range(12, 1);
            req_w[k] = WW'(w);
            req_m[k] = NT'($urandom);
            t = imax(req_a[k] + 1, free);
            tk[k] = t;
            free = (w == 0) ? t + 1 : t + 1 + w + int'(LAT);
            na = t + 1;
        end
        abort_x = NO_ABORT;
        if ($urandom_range(1, 0) == 1) begin
            abort_x = $urandom_range(free, 1);
            kept = 0;
            for (int k = 0; k < nreq; k++) if (req_a[k] <= abort_x) kept++;
            nreq = kept;
            rdy_ok = 1;
            for (int k = 0; k < nreq; k++)
                if ((abort_x > req_a[k] && abort_x <= tk[k]) || req_a[k] == abort_x) rdy_ok = 0;
            if (rdy_ok && nreq < MAXR && $urandom_range(2, 0) != 0) begin
                set_req(nreq, abort_x, AW'($urandom), $urandom_range(6, 0), NT'($urandom));
                nreq++;
            end
        end
        build_expect();
        if ($urandom_range(2, 0) == 0) end_e = $urandom_range(last_d + 2, 1);
        else end_e = last_d + 3;
        if (end_e > H - 3) end_e = H - 3;
    endtask

    task automatic setup_directed(input int p);
        abort_x = NO_ABORT;
        case (p)
            0: begin nreq = 1; set_req(0, 0, AW'(18'h00100), 4, 4'b0101); end
            1: begin nreq = 1; set_req(0, 0, AW'(18'h3FFFE), 4, 4'b1111); end
            2: begin nreq = 2; set_req(0, 0, AW'(18'h01000), 5, 4'b0011);
                               set_req(1, 2, AW'(18'h02000), 3, 4'b1100); end
            3: begin nreq = 2; set_req(0, 0, AW'(18'h00040), 0, 4'b1111);
                               set_req(1, 3, AW'(18'h00500), 6, 4'b0000); end
            4: begin nreq = 2; set_req(0, 0, AW'(18'h00300), 8, 4'b1111);
                               set_req(1, 4, AW'(18'h00700), 3, 4'b0010); abort_x = 4; end
            default: begin nreq = 2; set_req(0, 0, AW'(18'h00020), 3, 4'b1011);
                               set_req(1, 2, AW'(18'h00900), 4, 4'b0110); end
        endcase
        build_expect();
        end_e = (p == 5) ? 5 : last_d + 3;
    endtask

    task automatic check_reset(input string pfx);
        check_eq({pfx, "_ready"},   32'(req_ready_out), 32'd1);
        check_eq({pfx, "_mem_en"},  32'(mem_en_out),    32'd0);
        check_eq({pfx, "_addr"},    32'(mem_addr_out),  32'd0);
        check_eq({pfx, "_wr_en"},   32'(wr_en_out),     32'd0);
        check_eq({pfx, "_wr_addr"}, 32'(wr_addr_out),   32'd0);
        check_eq({pfx, "_busy"},    32'(busy_out),      32'd0);
        check_eq({pfx, "_done"},    32'(done_out),      32'd0);
    endtask

    task automatic run_phase();
        bit have;
        rst_in = 1'b1; req_valid_in = 1'b0; abort_in = 1'b0;
        req_base_in = '0; req_width_in = '0; req_mask_in = '0;
        @(posedge clk_in); #1;
        @(negedge clk_in);
        cyc = -1;
        check_reset("reset");
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        for (int c = 0; c <= end_e + 1; c++) begin
            if (c > 0) begin
                @(posedge clk_in); #1;
            end
            cyc = c;
            have = 0;
            req_valid_in = 1'b0;
            for (int k = 0; k < nreq; k++) begin
                if (req_a[k] == c && c < end_e) begin
                    have = 1;
                    req_base_in = req_base[k]; req_width_in = req_w[k]; req_mask_in = req_m[k];
                end
            end
            req_valid_in = have;
            if (!have) begin
                req_base_in = AW'($urandom); req_width_in = WW'($urandom); req_mask_in = NT'($urandom);
            end
            abort_in = (c == abort_x && c < end_e);
            rst_in = (c >= end_e);
            @(negedge clk_in);
            if (c <= end_e) begin
                check_eq("mem_en", 32'(mem_en_out), 32'(exp_en[c]));
                if (exp_en[c]) check_eq("mem_addr", 32'(mem_addr_out), 32'(exp_addr[c]));
                check_eq("wr_en", 32'(wr_en_out), 32'(exp_wen[c]));
                if (exp_wen[c] != '0) begin
                    check_eq("wr_addr", 32'(wr_addr_out), 32'(exp_widx[c]));
                    check_eq("wr_data", 32'(wr_data_out), 32'(exp_wdata[c]));
                end
                check_eq("done", 32'(done_out), 32'(exp_done[c]));
                check_eq("busy", 32'(busy_out), 32'(exp_busy[c]));
                check_eq("ready", 32'(req_ready_out), 32'(exp_rdy[c]));
            end else begin
                check_reset("post_rst");
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc = 0;
        rst_in = 1'b1; req_valid_in = 1'b0; abort_in = 1'b0;
        req_base_in = '0; req_width_in = '0; req_mask_in = '0;
        for (int p = 0; p < NPHASE; p++) begin
            phase = p;
            if (p < 6) setup_directed(p);
            else gen_random();
            run_phase();
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
